reg_write_arb: RTL

REG_WRITE_ARB -- requirements
Module: reg_write_arb

---
 rtl/reg_write_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_write_arb.sv
// Register-file write-port arbiter: pipeline writeback (A) vs. a 2-deep queue of
// multicycle-unit writes (B), with starvation hold-off and a pending-write scoreboard.
module reg_write_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [3:0]  a_rd,
  input  logic [15:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_rd,
  input  logic [15:0] b_data,
  input  logic        iss_valid,
  input  logic [3:0]  iss_rd,
  input  logic [3:0]  q_rs,
  input  logic [3:0]  q_rt,
  output logic        q_rs_busy,
  output logic        q_rt_busy,
  output logic        hold_a,
  output logic        rf_we,
  output logic [3:0]  rf_rd,
  output logic [15:0] rf_wd,
  output logic [2:0]  err
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // FIFO entry 0 is always the head; entries shift down on a pop.
  logic [3:0]    ent_rd   [2];
  logic [15:0]   ent_data [2];
  logic [1:0]    count;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   pending;
  logic [2:0]    err_q;
  logic          hold_q;

  logic          fifo_empty, fifo_full, push;
  logic          head_win, a_win, a_drop, conflict, retire_same, dup;
  logic [CW-1:0] wait_next;
  logic [15:0]   pend_next;

  always_comb begin
    fifo_empty  = (count == 2'd0);
    fifo_full   = (count == 2'd2);
    b_ready     = rst_n && !fifo_full;
    push        = b_valid && b_ready;
    head_win    = !fifo_empty && (hold_q || !a_valid);
    a_win       = a_valid && !hold_q;
    a_drop      = a_valid && hold_q;
    conflict    = a_win && (((count != 2'd0) && (ent_rd[0] == a_rd)) ||
                            (fifo_full && (ent_rd[1] == a_rd)));
    // A register whose pending write retires this very cycle may be re-issued cleanly.
    retire_same = head_win && (ent_rd[0] == iss_rd);
    dup         = iss_valid && pending[iss_rd] && !retire_same;
  end

  always_comb begin
    wait_next = '0;
    if (!fifo_empty && !head_win)
      wait_next = (wait_cnt >= LIMIT) ? wait_cnt : wait_cnt + CW'(1);
  end

  // Clear then set, so a same-cycle set on the retiring register wins.
  always_comb begin
    pend_next = pending;
    if (head_win)  pend_next[ent_rd[0]] = 1'b0;
    if (iss_valid) pend_next[iss_rd]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= 2'd0;
      wait_cnt <= '0;
      hold_q   <= 1'b0;
      pending  <= '0;
      err_q    <= '0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wd    <= '0;
    end else begin
      case ({push, head_win})
        2'b01: begin
          ent_rd[0]   <= ent_rd[1];
          ent_data[0] <= ent_data[1];
          count       <= count - 2'd1;
        end
        2'b10: begin
          ent_rd[count[0]]   <= b_rd;
          ent_data[count[0]] <= b_data;
          count              <= count + 2'd1;
        end
        2'b11: begin
          // Push needs a free slot and pop needs an entry, so exactly one is held.
          ent_rd[0]   <= b_rd;
          ent_data[0] <= b_data;
        end
        default: ;
      endcase
      wait_cnt <= wait_next;
      hold_q   <= (wait_next >= LIMIT);
      pending  <= pend_next;
      err_q    <= err_q | {a_drop, dup, conflict};
      rf_we    <= a_win || head_win;
      rf_rd    <= head_win ? ent_rd[0]   : (a_win ? a_rd   : 4'd0);
      rf_wd    <= head_win ? ent_data[0] : (a_win ? a_data : 16'd0);
    end
  end

  assign q_rs_busy = pending[q_rs];
  assign q_rt_busy = pending[q_rt];
  assign hold_a    = hold_q;
  assign err       = err_q;

endmodule
